// File: rtl/instr_loader.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | instr_loader: framed byte stream (len, words, xor csum) -> instr memory |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module instr_loader #(
  parameter int          TEXT_BYTES = 1024,
  parameter logic [31:0] TEXT_START = 32'h0040_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic        in_valid_i,
  input  logic [7:0]  in_data_i,
  output logic        in_ready_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic        cpu_rstn_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        error_o,
  output logic [15:0] words_loaded_o
);

  localparam logic [31:0] MAX_WORDS = 32'(TEXT_BYTES / 4);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LEN0  = 3'd1,
    S_LEN1  = 3'd2,
    S_DATA  = 3'd3,
    S_CSUM  = 3'd4,
    S_DONE  = 3'd5,
    S_ERROR = 3'd6
  } state_t;

  state_t      state_q;
  logic [15:0] len_q;
  logic [7:0]  xor_q;
  logic [31:0] word_q;
  logic [1:0]  byte_cnt_q;
  logic        mem_we_q;
  logic [31:0] mem_addr_q;
  logic [31:0] mem_wdata_q;
  logic        cpu_rstn_q;
  logic        busy_q;
  logic        done_q;
  logic        error_q;
  logic [15:0] words_loaded_q;

  logic        accept_d;
  logic [15:0] len_d;
  logic [31:0] word_d;
  logic [7:0]  xor_d;
  logic [31:0] addr_d;
  logic        last_word_d;

  assign in_ready_o  = (state_q == S_LEN0) || (state_q == S_LEN1) ||
                       (state_q == S_DATA) || (state_q == S_CSUM);
  assign accept_d    = in_valid_i && in_ready_o;
  assign len_d       = {in_data_i, len_q[7:0]};
  // Bytes shift in from the top so the first byte lands in [7:0] after four.
  assign word_d      = {in_data_i, word_q[31:8]};
  assign xor_d       = xor_q ^ in_data_i;
  // words_loaded_q is the 0-based index of the word being completed.
  assign addr_d      = TEXT_START + {14'b0, words_loaded_q, 2'b00};
  assign last_word_d = (words_loaded_q + 16'd1) == len_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      len_q          <= '0;
      xor_q          <= '0;
      word_q         <= '0;
      byte_cnt_q     <= '0;
      mem_we_q       <= 1'b0;
      mem_addr_q     <= TEXT_START;
      mem_wdata_q    <= '0;
      cpu_rstn_q     <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      error_q        <= 1'b0;
      words_loaded_q <= '0;
    end else begin
      mem_we_q <= 1'b0;
      case (state_q)
        S_IDLE, S_DONE, S_ERROR: begin
          if (start_i) begin
            state_q        <= S_LEN0;
            done_q         <= 1'b0;
            error_q        <= 1'b0;
            cpu_rstn_q     <= 1'b0;
            words_loaded_q <= '0;
            xor_q          <= '0;
            byte_cnt_q     <= '0;
            busy_q         <= 1'b1;
          end
        end
        S_LEN0: begin
          if (accept_d) begin
            len_q[7:0] <= in_data_i;
            xor_q      <= xor_d;
            state_q    <= S_LEN1;
          end
        end
        S_LEN1: begin
          if (accept_d) begin
            len_q <= len_d;
            xor_q <= xor_d;
            if (32'(len_d) > MAX_WORDS) begin
              state_q <= S_ERROR;
              error_q <= 1'b1;
              busy_q  <= 1'b0;
            end else if (len_d == 16'd0) begin
              state_q <= S_CSUM;
            end else begin
              state_q <= S_DATA;
            end
          end
        end
        S_DATA: begin
          if (accept_d) begin
            xor_q      <= xor_d;
            word_q     <= word_d;
            byte_cnt_q <= byte_cnt_q + 2'd1;
            if (byte_cnt_q == 2'd3) begin
              mem_we_q       <= 1'b1;
              mem_addr_q     <= addr_d;
              mem_wdata_q    <= word_d;
              words_loaded_q <= words_loaded_q + 16'd1;
              if (last_word_d) begin
                state_q <= S_CSUM;
              end
            end
          end
        end
        S_CSUM: begin
          if (accept_d) begin
            busy_q <= 1'b0;
            if (in_data_i == xor_q) begin
              state_q    <= S_DONE;
              done_q     <= 1'b1;
              cpu_rstn_q <= 1'b1;
            end else begin
              state_q    <= S_ERROR;
              error_q    <= 1'b1;
              cpu_rstn_q <= 1'b0;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign mem_we_o       = mem_we_q;
  assign mem_addr_o     = mem_addr_q;
  assign mem_wdata_o    = mem_wdata_q;
  assign cpu_rstn_o     = cpu_rstn_q;
  assign busy_o         = busy_q;
  assign done_o         = done_q;
  assign error_o        = error_q;
  assign words_loaded_o = words_loaded_q;

endmodule
`default_nettype wire

// File: tb/tb_instr_loader.sv
`default_nettype none
// tb_instr_loader: randomized frames checked against a queue-based frame model.
module tb_instr_loader;

  localparam logic [31:0] TS = 32'h0040_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i;
  logic        in_valid_i;
  logic [7:0]  in_data_i;
  logic        in_ready_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic        cpu_rstn_o;
  logic        busy_o;
  logic        done_o;
  logic        error_o;
  logic [15:0] words_loaded_o;

  instr_loader #(.TEXT_BYTES(1024), .TEXT_START(TS)) dut (
    .clk            (clk),
    .rst            (rst),
    .start_i        (start_i),
    .in_valid_i     (in_valid_i),
    .in_data_i      (in_data_i),
    .in_ready_o     (in_ready_o),
    .mem_we_o       (mem_we_o),
    .mem_addr_o     (mem_addr_o),
    .mem_wdata_o    (mem_wdata_o),
    .cpu_rstn_o     (cpu_rstn_o),
    .busy_o         (busy_o),
    .done_o         (done_o),
    .error_o        (error_o),
    .words_loaded_o (words_loaded_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int pulse_viol = 0;
  logic prev_we = 1'b0;
  logic [31:0] obs_a[$], obs_d[$], exp_a[$], exp_d[$];
  logic [7:0]  fr[$];

  // Write-port monitor: one entry per cycle the strobe is high.
  always @(negedge clk) begin
    if (mem_we_o === 1'b1) begin
      obs_a.push_back(mem_addr_o);
      obs_d.push_back(mem_wdata_o);
      if (prev_we) pulse_viol++;
    end
    prev_we = (mem_we_o === 1'b1);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic clear_obs();
    obs_a.delete(); obs_d.delete(); pulse_viol = 0;
  endtask

  task automatic do_start();
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int t = 0;
    in_valid_i = 1'b0;
    repeat (gap) @(negedge clk);
    in_valid_i = 1'b1;
    in_data_i  = b;
    while (in_ready_o !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (in_ready_o !== 1'b1) begin
      n_checks++;
      $display("FAIL byte_accept: in_ready=%b after %0d cycles, want 1", in_ready_o, t);
    end
    @(negedge clk);
    in_valid_i = 1'b0;
  endtask

  // Frame model: N words of random data, checksum = XOR of all earlier bytes.
  task automatic build_frame(input int n, input bit bad);
    logic [31:0] w;
    logic [7:0]  cs;
    fr.delete(); exp_a.delete(); exp_d.delete();
    fr.push_back(8'(n));
    fr.push_back(8'(n >> 8));
    for (int k = 0; k < n; k++) begin
      w = $urandom;
      for (int j = 0; j < 4; j++) fr.push_back(8'(w >> (8 * j)));
      exp_a.push_back(TS + 32'(4 * k));
      exp_d.push_back(w);
    end
    cs = 8'h00;
    foreach (fr[i]) cs ^= fr[i];
    if (bad) cs ^= 8'($urandom_range(255, 1));
    fr.push_back(cs);
  endtask

  task automatic load_s1_frame(input logic [7:0] cs);
    fr = '{8'h01, 8'h00, 8'h20, 8'h08, 8'h00, 8'h05, cs};
    exp_a = '{TS};
    exp_d = '{32'h0500_0820};
  endtask

  task automatic send_frame(input int gmin, input int gmax, input int start_at);
    foreach (fr[i]) begin
      if (i == start_at) do_start();
      send_byte(fr[i], int'($urandom_range(gmax, gmin)));
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; start_i = 1'b0; in_valid_i = 1'b0; in_data_i = 8'h00;
    repeat (3) @(negedge clk);
    n_checks++; if (in_ready_o !== 1'b0) $display("FAIL rst_in_ready: got %b want 0", in_ready_o); else n_pass++;
    n_checks++; if (mem_we_o !== 1'b0) $display("FAIL rst_mem_we: got %b want 0", mem_we_o); else n_pass++;
    n_checks++; if (mem_addr_o !== TS) $display("FAIL rst_mem_addr: got %h want %h", mem_addr_o, TS); else n_pass++;
    n_checks++; if (mem_wdata_o !== 32'h0) $display("FAIL rst_mem_wdata: got %h want 0", mem_wdata_o); else n_pass++;
    n_checks++; if ({cpu_rstn_o, busy_o, done_o, error_o} !== 4'b0000)
      $display("FAIL rst_status: got rstn/busy/done/err=%b want 0000", {cpu_rstn_o, busy_o, done_o, error_o}); else n_pass++;
    n_checks++; if (words_loaded_o !== 16'd0) $display("FAIL rst_words: got %0d want 0", words_loaded_o); else n_pass++;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single_word();
    clear_obs();
    do_start();
    n_checks++; if (busy_o !== 1'b1) $display("FAIL s1_busy: got %b want 1", busy_o); else n_pass++;
    load_s1_frame(8'h2C);
    send_frame(0, 0, -1);
    n_checks++; if (obs_a.size() !== 1) $display("FAIL s1_nwrites: got %0d want 1", obs_a.size()); else n_pass++;
    if (obs_a.size() > 0) begin
      n_checks++; if (obs_a[0] !== 32'h0040_0000) $display("FAIL s1_addr: got %h want 00400000", obs_a[0]); else n_pass++;
      n_checks++; if (obs_d[0] !== 32'h0500_0820) $display("FAIL s1_data: got %h want 05000820", obs_d[0]); else n_pass++;
    end
    n_checks++; if ({done_o, cpu_rstn_o, error_o, busy_o} !== 4'b1100)
      $display("FAIL s1_status: got done/rstn/err/busy=%b want 1100", {done_o, cpu_rstn_o, error_o, busy_o}); else n_pass++;
    n_checks++; if (words_loaded_o !== 16'd1) $display("FAIL s1_words: got %0d want 1", words_loaded_o); else n_pass++;
    n_checks++; if (mem_addr_o !== TS) $display("FAIL s1_addr_hold: got %h want %h", mem_addr_o, TS); else n_pass++;
  endtask

  task automatic test_gaps();
    clear_obs();
    do_start();
    build_frame(2, 1'b0);
    send_frame(3, 3, 5);
    n_checks++; if (obs_a.size() !== 2) $display("FAIL gap_nwrites: got %0d want 2", obs_a.size()); else n_pass++;
    for (int i = 0; i < obs_a.size() && i < 2; i++) begin
      n_checks++; if (obs_a[i] !== exp_a[i]) $display("FAIL gap_addr%0d: got %h want %h", i, obs_a[i], exp_a[i]); else n_pass++;
      n_checks++; if (obs_d[i] !== exp_d[i]) $display("FAIL gap_data%0d: got %h want %h", i, obs_d[i], exp_d[i]); else n_pass++;
    end
    n_checks++; if (pulse_viol !== 0) $display("FAIL gap_pulse_width: got %0d long pulses want 0", pulse_viol); else n_pass++;
    n_checks++; if (done_o !== 1'b1) $display("FAIL gap_done: got %b want 1", done_o); else n_pass++;
    n_checks++; if (words_loaded_o !== 16'd2) $display("FAIL gap_words: got %0d want 2", words_loaded_o); else n_pass++;
  endtask

  task automatic test_len_error();
    clear_obs();
    do_start();
    send_byte(8'h01, 0);
    send_byte(8'h01, 0);
    n_checks++; if (in_ready_o !== 1'b0) $display("FAIL len_in_ready: got %b want 0", in_ready_o); else n_pass++;
    in_valid_i = 1'b1; in_data_i = 8'hAA;
    repeat (3) @(negedge clk);
    in_valid_i = 1'b0;
    n_checks++; if ({error_o, busy_o, done_o, cpu_rstn_o} !== 4'b1000)
      $display("FAIL len_status: got err/busy/done/rstn=%b want 1000", {error_o, busy_o, done_o, cpu_rstn_o}); else n_pass++;
    n_checks++; if (in_ready_o !== 1'b0) $display("FAIL len_in_ready_hold: got %b want 0", in_ready_o); else n_pass++;
    n_checks++; if (obs_a.size() !== 0) $display("FAIL len_nwrites: got %0d want 0", obs_a.size()); else n_pass++;
  endtask

  task automatic test_bad_csum();
    clear_obs();
    do_start();
    load_s1_frame(8'h2D);
    send_frame(0, 1, -1);
    n_checks++; if (obs_a.size() !== 1) $display("FAIL badcs_nwrites: got %0d want 1", obs_a.size()); else n_pass++;
    if (obs_d.size() > 0) begin
      n_checks++; if (obs_d[0] !== exp_d[0]) $display("FAIL badcs_data: got %h want %h", obs_d[0], exp_d[0]); else n_pass++;
    end
    n_checks++; if ({error_o, done_o, cpu_rstn_o, busy_o} !== 4'b1000)
      $display("FAIL badcs_status: got err/done/rstn/busy=%b want 1000", {error_o, done_o, cpu_rstn_o, busy_o}); else n_pass++;
    do_start();
    n_checks++; if ({error_o, busy_o, words_loaded_o} !== {2'b01, 16'd0})
      $display("FAIL restart_clear: got err=%b busy=%b words=%0d want 0 1 0", error_o, busy_o, words_loaded_o); else n_pass++;
    clear_obs();
    build_frame(3, 1'b0);
    send_frame(0, 2, -1);
    n_checks++; if (obs_a.size() !== 3) $display("FAIL restart_nwrites: got %0d want 3", obs_a.size()); else n_pass++;
    n_checks++; if ({done_o, error_o, words_loaded_o} !== {2'b10, 16'd3})
      $display("FAIL restart_status: got done=%b err=%b words=%0d want 1 0 3", done_o, error_o, words_loaded_o); else n_pass++;
  endtask

  task automatic test_rst_midload();
    clear_obs();
    do_start();
    load_s1_frame(8'h2C);
    for (int i = 0; i < 4; i++) send_byte(fr[i], 0);
    rst = 1'b1;
    @(negedge clk);
    n_checks++; if ({in_ready_o, mem_we_o, cpu_rstn_o, busy_o, done_o, error_o} !== 6'b0)
      $display("FAIL midrst_status: got rdy/we/rstn/busy/done/err=%b want 000000",
               {in_ready_o, mem_we_o, cpu_rstn_o, busy_o, done_o, error_o}); else n_pass++;
    n_checks++; if ({mem_addr_o, mem_wdata_o, words_loaded_o} !== {TS, 32'h0, 16'h0})
      $display("FAIL midrst_regs: got addr=%h wdata=%h words=%0d want %h 0 0", mem_addr_o, mem_wdata_o, words_loaded_o, TS); else n_pass++;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++; if (in_ready_o !== 1'b0) $display("FAIL midrst_idle: got in_ready=%b want 0", in_ready_o); else n_pass++;
    n_checks++; if (obs_a.size() !== 0) $display("FAIL midrst_nwrites: got %0d want 0", obs_a.size()); else n_pass++;
    do_start();
    send_frame(0, 0, -1);
    n_checks++; if (obs_a.size() !== 1 || obs_d[0] !== 32'h0500_0820)
      $display("FAIL midrst_reload: got %0d writes want 1 of 05000820", obs_a.size()); else n_pass++;
    n_checks++; if ({done_o, cpu_rstn_o} !== 2'b11) $display("FAIL midrst_done: got done/rstn=%b want 11", {done_o, cpu_rstn_o}); else n_pass++;
  endtask

  task automatic test_zero_len();
    clear_obs();
    do_start();
    fr = '{8'h00, 8'h00, 8'h00};
    send_frame(0, 0, -1);
    n_checks++; if (obs_a.size() !== 0) $display("FAIL zero_nwrites: got %0d want 0", obs_a.size()); else n_pass++;
    n_checks++; if ({done_o, cpu_rstn_o, error_o, words_loaded_o} !== {3'b110, 16'd0})
      $display("FAIL zero_status: got done=%b rstn=%b err=%b words=%0d want 1 1 0 0", done_o, cpu_rstn_o, error_o, words_loaded_o); else n_pass++;
  endtask

  task automatic test_max_len();
    int nerr = 0;
    clear_obs();
    do_start();
    build_frame(256, 1'b0);
    send_frame(0, 0, -1);
    n_checks++; if (obs_a.size() !== 256) $display("FAIL max_nwrites: got %0d want 256", obs_a.size()); else n_pass++;
    for (int i = 0; i < obs_a.size() && i < 256; i++) begin
      if (obs_a[i] !== exp_a[i] || obs_d[i] !== exp_d[i]) nerr++;
    end
    n_checks++; if (nerr !== 0) $display("FAIL max_contents: got %0d bad writes want 0", nerr); else n_pass++;
    n_checks++; if ({done_o, words_loaded_o} !== {1'b1, 16'd256})
      $display("FAIL max_status: got done=%b words=%0d want 1 256", done_o, words_loaded_o); else n_pass++;
  endtask

  task automatic test_random();
    for (int it = 0; it < 8; it++) begin
      int  n   = int'($urandom_range(8, 0));
      bit  bad = ($urandom_range(3, 0) == 0);
      clear_obs();
      do_start();
      build_frame(n, bad);
      send_frame(0, 2, -1);
      n_checks++; if (obs_a.size() !== n) $display("FAIL rnd%0d_nwrites: got %0d want %0d", it, obs_a.size(), n); else n_pass++;
      for (int i = 0; i < obs_a.size() && i < n; i++) begin
        n_checks++; if (obs_a[i] !== exp_a[i] || obs_d[i] !== exp_d[i])
          $display("FAIL rnd%0d_write%0d: got %h@%h want %h@%h", it, i, obs_d[i], obs_a[i], exp_d[i], exp_a[i]); else n_pass++;
      end
      n_checks++; if ({done_o, error_o, cpu_rstn_o, busy_o} !== {!bad, bad, !bad, 1'b0})
        $display("FAIL rnd%0d_status: got done/err/rstn/busy=%b want %b", it,
                 {done_o, error_o, cpu_rstn_o, busy_o}, {!bad, bad, !bad, 1'b0}); else n_pass++;
      n_checks++; if (words_loaded_o !== 16'(n)) $display("FAIL rnd%0d_words: got %0d want %0d", it, words_loaded_o, n); else n_pass++;
      n_checks++; if (pulse_viol !== 0) $display("FAIL rnd%0d_pulse_width: got %0d want 0", it, pulse_viol); else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_gaps();
    test_len_error();
    test_bad_csum();
    test_rst_midload();
    test_zero_len();
    test_max_len();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
